program_counter: RTL

//   Fetch-address sequencer directly downstream of the branch-decision unit.

---
 rtl/program_counter.sv | 96 +++++++++
 1 files changed

// File: rtl/program_counter.sv
// Fetch-address sequencer: owns the ROM PC, runs the start/done program handshake, counts retired instructions.
// Branch redirect takes effect at the sampling edge (no delay slot); stall freezes all state for that cycle.
module program_counter #(
  parameter int unsigned PC_W       = 9,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             branch,
  input  logic [PC_W-1:0]  target,
  input  logic             halt,
  input  logic             stall,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  // Retire counter saturates rather than wrapping so long runs never read as short ones.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        pc_d = START_PC;
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          cnt_d = cnt_inc;
          if (halt) begin
            state_d = S_HALTED;
          end else if (branch) begin
            pc_d = target;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      S_HALTED: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = START_PC;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_HALTED);

endmodule
